// File: rtl/genius_round_ctrl.sv
// Round sequencer for the GENIUS (Simon) game: latches setup, runs show/input rounds,
// keeps the round counter and the registered score, and times out idle players.
module genius_round_ctrl #(
   parameter int MAX_ROUND   = 15,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       ENTER,
   input  logic [1:0] SETUP_LEVEL,
   input  logic [1:0] SETUP_MAPA,
   input  logic       SEQ_DONE,
   input  logic       BTN_VALID,
   input  logic       BTN_MATCH,
   input  logic       BTN_LAST,
   output logic [1:0] REG_SetupLEVEL,
   output logic [1:0] REG_SetupMAPA,
   output logic [3:0] ROUND,
   output logic [7:0] POINTS,
   output logic       SHOW_START,
   output logic       INPUT_EN,
   output logic       WIN,
   output logic       LOSE
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETUP    = 3'd1;
   localparam logic [2:0] ST_SHOW     = 3'd2;
   localparam logic [2:0] ST_WAIT_SEQ = 3'd3;
   localparam logic [2:0] ST_INPUT    = 3'd4;
   localparam logic [2:0] ST_NEXT     = 3'd5;
   localparam logic [2:0] ST_WIN      = 3'd6;
   localparam logic [2:0] ST_LOSE     = 3'd7;

   localparam int               CNT_W        = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]       ROUND_LAST   = 4'(MAX_ROUND);

   logic [2:0]       state_reg, state_next;
   logic [1:0]       level_reg, map_reg;
   logic [3:0]       round_reg;
   logic [7:0]       points_reg;
   logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

   logic             start_ok;
   logic             timed_out;
   logic             final_round;
   logic [3:0]       round_inc;
   logic [7:0]       points_next;

   assign start_ok    = ENTER && (SETUP_LEVEL != 2'b00);
   assign timed_out   = (idle_cnt_reg == TIMEOUT_LAST);
   assign round_inc   = round_reg + 4'd1;
   // Score is recomputed from the latched level, never accumulated, so it cannot drift.
   assign points_next = {6'd0, level_reg} * {4'd0, round_inc};
   assign final_round = (round_inc == ROUND_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (start_ok) state_next = ST_SETUP;
         ST_SETUP:    state_next = ST_SHOW;
         ST_SHOW:     state_next = ST_WAIT_SEQ;
         ST_WAIT_SEQ: if (SEQ_DONE) state_next = ST_INPUT;
         ST_INPUT: begin
            // A press in the timeout cycle takes priority over the timeout.
            if (BTN_VALID) begin
               if (!BTN_MATCH)    state_next = ST_LOSE;
               else if (BTN_LAST) state_next = ST_NEXT;
            end else if (timed_out) begin
               state_next = ST_LOSE;
            end
         end
         ST_NEXT:     state_next = final_round ? ST_WIN : ST_SHOW;
         ST_WIN:      if (ENTER) state_next = ST_IDLE;
         ST_LOSE:     if (ENTER) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Idle counter only runs inside INPUT; any other state parks it at zero.
   always_comb begin
      idle_cnt_next = '0;
      if (state_reg == ST_INPUT && !BTN_VALID && !timed_out)
         idle_cnt_next = idle_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_reg    <= ST_IDLE;
         idle_cnt_reg <= '0;
         level_reg    <= 2'b00;
         map_reg      <= 2'b00;
         round_reg    <= 4'd0;
         points_reg   <= 8'd0;
      end else begin
         state_reg    <= state_next;
         idle_cnt_reg <= idle_cnt_next;
         if (state_reg == ST_SETUP) begin
            level_reg  <= SETUP_LEVEL;
            map_reg    <= SETUP_MAPA;
            round_reg  <= 4'd0;
            points_reg <= 8'd0;
         end else if (state_reg == ST_NEXT) begin
            round_reg  <= round_inc;
            points_reg <= points_next;
         end
      end
   end

   assign REG_SetupLEVEL = level_reg;
   assign REG_SetupMAPA  = map_reg;
   assign ROUND          = round_reg;
   assign POINTS         = points_reg;
   assign SHOW_START     = (state_reg == ST_SHOW);
   assign INPUT_EN       = (state_reg == ST_INPUT);
   assign WIN            = (state_reg == ST_WIN);
   assign LOSE           = (state_reg == ST_LOSE);

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Bench for genius_round_ctrl: directed game scenarios with literal expectations, then
// random play, all checked every cycle against a game-level reference model.
module tb_genius_round_ctrl;

   localparam int MAX_R = 3;
   localparam int TOUT  = 8;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic       ENTER = 1'b0;
   logic [1:0] SETUP_LEVEL = 2'b00;
   logic [1:0] SETUP_MAPA = 2'b00;
   logic       SEQ_DONE = 1'b0;
   logic       BTN_VALID = 1'b0;
   logic       BTN_MATCH = 1'b0;
   logic       BTN_LAST = 1'b0;
   logic [1:0] REG_SetupLEVEL;
   logic [1:0] REG_SetupMAPA;
   logic [3:0] ROUND;
   logic [7:0] POINTS;
   logic       SHOW_START;
   logic       INPUT_EN;
   logic       WIN;
   logic       LOSE;

   int n_vec = 0;
   int n_err = 0;

   genius_round_ctrl #(.MAX_ROUND(MAX_R), .TIMEOUT_CYC(TOUT)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .ENTER(ENTER),
      .SETUP_LEVEL(SETUP_LEVEL), .SETUP_MAPA(SETUP_MAPA),
      .SEQ_DONE(SEQ_DONE), .BTN_VALID(BTN_VALID), .BTN_MATCH(BTN_MATCH), .BTN_LAST(BTN_LAST),
      .REG_SetupLEVEL(REG_SetupLEVEL), .REG_SetupMAPA(REG_SetupMAPA),
      .ROUND(ROUND), .POINTS(POINTS), .SHOW_START(SHOW_START),
      .INPUT_EN(INPUT_EN), .WIN(WIN), .LOSE(LOSE)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: where the game is, what was latched, how far the player got.
   typedef enum int {G_IDLE, G_SETUP, G_SHOW, G_WAIT, G_INPUT, G_NEXT, G_WIN, G_LOSE} game_t;
   game_t m_phase = G_IDLE;
   int    m_lvl = 0, m_map = 0, m_round = 0, m_idle = 0;

   task automatic model_reset();
      m_phase = G_IDLE; m_lvl = 0; m_map = 0; m_round = 0; m_idle = 0;
   endtask

   task automatic model_step();
      case (m_phase)
         G_IDLE:  if (ENTER && SETUP_LEVEL != 0) m_phase = G_SETUP;
         G_SETUP: begin
            m_lvl = SETUP_LEVEL; m_map = SETUP_MAPA; m_round = 0; m_phase = G_SHOW;
         end
         G_SHOW:  m_phase = G_WAIT;
         G_WAIT:  if (SEQ_DONE) begin m_phase = G_INPUT; m_idle = 0; end
         G_INPUT: begin
            if (BTN_VALID) begin
               m_idle = 0;
               if (!BTN_MATCH)    m_phase = G_LOSE;
               else if (BTN_LAST) m_phase = G_NEXT;
            end else if (m_idle == TOUT - 1) begin
               m_phase = G_LOSE;
            end else begin
               m_idle++;
            end
         end
         G_NEXT: begin
            m_round++;
            m_phase = (m_round == MAX_R) ? G_WIN : G_SHOW;
         end
         default: if (ENTER) m_phase = G_IDLE;
      endcase
   endtask

   // Compare process: model advances on each edge, DUT is sampled 1 time unit later.
   always begin
      @(posedge CLOCK);
      if (!RESET) model_reset();
      else        model_step();
      #1;
      check("reg_level",  REG_SetupLEVEL, m_lvl);
      check("reg_map",    REG_SetupMAPA,  m_map);
      check("round",      ROUND,          m_round);
      check("points",     POINTS,         m_lvl * m_round);
      check("show_start", SHOW_START,     int'(m_phase == G_SHOW));
      check("input_en",   INPUT_EN,       int'(m_phase == G_INPUT));
      check("win",        WIN,            int'(m_phase == G_WIN));
      check("lose",       LOSE,           int'(m_phase == G_LOSE));
   end

   logic [1:0] cur_lvl = 2'd0;
   logic [1:0] cur_map = 2'd0;

   task automatic step(input logic en, input logic seq, input logic v,
                       input logic m, input logic l);
      ENTER = en; SETUP_LEVEL = cur_lvl; SETUP_MAPA = cur_map;
      SEQ_DONE = seq; BTN_VALID = v; BTN_MATCH = m; BTN_LAST = l;
      @(negedge CLOCK);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   // From SHOW: display, a stray press during display, two correct presses, then NEXT.
   task automatic round_ok();
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) @(negedge CLOCK);
      RESET = 1'b1;
      check("rst_round", ROUND, 0);
      check("rst_points", POINTS, 0);
      check("rst_win", WIN, 0);

      cur_lvl = 2'd0; step(1, 0, 0, 0, 0); idle(1);
      check("lvl0_ignored", SHOW_START, 0);

      cur_lvl = 2'd2; cur_map = 2'd2;
      step(1, 0, 0, 0, 0); idle(1);
      check("g1_show", SHOW_START, 1);
      check("g1_map", REG_SetupMAPA, 2);
      round_ok();
      check("g1_r1_round", ROUND, 1);
      check("g1_r1_points", POINTS, 2);
      check("g1_r1_show", SHOW_START, 1);
      cur_lvl = 2'd1;
      round_ok();
      check("g1_r2_points", POINTS, 4);
      check("g1_r2_level", REG_SetupLEVEL, 2);
      round_ok();
      check("g1_win", WIN, 1);
      check("g1_r3_round", ROUND, 3);
      check("g1_r3_points", POINTS, 6);
      idle(2);
      check("g1_no_show", SHOW_START, 0);
      step(1, 0, 0, 0, 0);
      check("g1_idle_win", WIN, 0);
      check("g1_idle_pts", POINTS, 6);

      cur_lvl = 2'd3;
      step(1, 0, 0, 0, 0); idle(1);
      round_ok();
      idle(1); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
      check("g2_lose", LOSE, 1);
      check("g2_round", ROUND, 1);
      check("g2_points", POINTS, 3);
      step(1, 0, 0, 0, 0);
      check("g2_idle", LOSE, 0);

      cur_lvl = 2'd1;
      step(1, 0, 0, 0, 0); idle(2); step(0, 1, 0, 0, 0);
      idle(TOUT - 1);
      check("to_cycle8", INPUT_EN, 1);
      idle(1);
      check("to_lose", LOSE, 1);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0); idle(2); step(0, 1, 0, 0, 0);
      idle(TOUT - 1);
      step(0, 0, 1, 1, 0);
      check("to_press_stay", INPUT_EN, 1);
      idle(TOUT - 1);
      check("to_rearm_in", INPUT_EN, 1);
      idle(1);
      check("to_rearm_lose", LOSE, 1);
      step(1, 0, 0, 0, 0);

      cur_lvl = 2'd2;
      step(1, 0, 0, 0, 0); idle(1); round_ok();
      idle(1); step(0, 1, 0, 0, 0);
      check("ar_pre_input", INPUT_EN, 1);
      step(0, 0, 0, 0, 0);
      #2 RESET = 1'b0;
      #1;
      check("ar_input_en", INPUT_EN, 0);
      check("ar_round", ROUND, 0);
      check("ar_points", POINTS, 0);
      check("ar_level", REG_SetupLEVEL, 0);
      @(negedge CLOCK);
      RESET = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         RESET = ($urandom_range(0, 399) != 0);
         cur_lvl = 2'($urandom_range(0, 3));
         cur_map = 2'($urandom_range(0, 3));
         step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 92,
              $urandom_range(0, 99) < 35);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
